// File: rtl/alarm_buzzer_ctrl.sv
// Alarm buzzer controller: sequences ring / snooze / mute for one alarm event
// and drives a tone that is gated half a second on, half a second off.
module alarm_buzzer_ctrl #(
  parameter int TONE_HALF  = 5000,
  parameter int QTR_CYCLES = 7_812_500,
  parameter int RING_MAX   = 60,
  parameter int SNOOZE_SEC = 300,
  parameter int MAX_SNOOZE = 3
) (
  input  logic clk,
  input  logic reset_n,
  input  logic alarm_trig,
  input  logic snooze_pulse,
  input  logic stop_pulse,
  output logic buzzer_out,
  output logic ringing,
  output logic snoozing,
  output logic muted
);

  localparam int TW      = (TONE_HALF > 1) ? $clog2(TONE_HALF) : 1;
  localparam int QW      = (QTR_CYCLES > 1) ? $clog2(QTR_CYCLES) : 1;
  localparam int SEC_TOP = (RING_MAX > SNOOZE_SEC) ? RING_MAX : SNOOZE_SEC;
  localparam int SW      = (SEC_TOP > 0) ? $clog2(SEC_TOP + 1) : 1;
  localparam int NW      = (MAX_SNOOZE > 0) ? $clog2(MAX_SNOOZE + 1) : 1;

  localparam logic [TW-1:0] TONE_LAST = TW'(TONE_HALF - 1);
  localparam logic [QW-1:0] QTR_LAST  = QW'(QTR_CYCLES - 1);
  localparam logic [SW-1:0] RING_LIM  = SW'(RING_MAX);
  localparam logic [SW-1:0] SNZ_LIM   = SW'(SNOOZE_SEC);
  localparam logic [NW-1:0] SNZ_MAX   = NW'(MAX_SNOOZE);

  // One-hot so the status outputs are plain register bits and cannot glitch.
  typedef enum logic [3:0] {
    IDLE    = 4'b0001,
    RINGING = 4'b0010,
    SNOOZE  = 4'b0100,
    MUTED   = 4'b1000
  } state_t;

  state_t          state, state_nxt;
  logic [TW-1:0]   tone_cnt;
  logic            tone_q;
  logic [QW-1:0]   qtr_cnt;
  logic [1:0]      qtr_idx;
  logic [SW-1:0]   sec_cnt;
  logic [SW-1:0]   sec_inc;
  logic [NW-1:0]   snz_cnt;

  logic            qtr_run;
  logic            qtr_tick;
  logic            sec_tick;
  logic            ring_done;
  logic            snz_done;
  logic            snz_ok;
  logic            enter_ring;
  logic            enter_snz;
  logic            clr_snz;

  assign qtr_run   = state[1] | state[2];
  assign qtr_tick  = qtr_run && (qtr_cnt == QTR_LAST);
  assign sec_tick  = qtr_tick && (qtr_idx == 2'd3);
  assign sec_inc   = sec_cnt + SW'(1);
  assign ring_done = sec_tick && (sec_inc == RING_LIM);
  assign snz_done  = sec_tick && (sec_inc == SNZ_LIM);
  assign snz_ok    = (snz_cnt < SNZ_MAX);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Dropping alarm_trig outranks everything; stop outranks snooze.
  always_comb begin
    state_nxt  = state;
    enter_ring = 1'b0;
    enter_snz  = 1'b0;
    clr_snz    = 1'b0;
    case (state)
      IDLE: begin
        if (alarm_trig) begin
          state_nxt  = RINGING;
          enter_ring = 1'b1;
        end
      end
      RINGING: begin
        if (!alarm_trig) begin
          state_nxt = IDLE;
          clr_snz   = 1'b1;
        end else if (stop_pulse) begin
          state_nxt = MUTED;
        end else if (snooze_pulse && snz_ok) begin
          state_nxt = SNOOZE;
          enter_snz = 1'b1;
        end else if (ring_done) begin
          state_nxt = MUTED;
        end
      end
      SNOOZE: begin
        if (!alarm_trig) begin
          state_nxt = IDLE;
          clr_snz   = 1'b1;
        end else if (stop_pulse) begin
          state_nxt = MUTED;
        end else if (snz_done) begin
          state_nxt  = RINGING;
          enter_ring = 1'b1;
        end
      end
      MUTED: begin
        if (!alarm_trig) begin
          state_nxt = IDLE;
          clr_snz   = 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
        clr_snz   = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tone_cnt <= '0;
      tone_q   <= 1'b0;
    end else if (enter_ring) begin
      tone_cnt <= '0;
      tone_q   <= 1'b0;
    end else if (state == RINGING) begin
      if (tone_cnt == TONE_LAST) begin
        tone_cnt <= '0;
        tone_q   <= ~tone_q;
      end else begin
        tone_cnt <= tone_cnt + TW'(1);
      end
    end
  end

  // Quarter-second timebase shared by ring timeout and snooze duration.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      qtr_cnt <= '0;
      qtr_idx <= 2'd0;
      sec_cnt <= '0;
    end else if (enter_ring || enter_snz) begin
      qtr_cnt <= '0;
      qtr_idx <= 2'd0;
      sec_cnt <= '0;
    end else if (qtr_run) begin
      if (qtr_tick) begin
        qtr_cnt <= '0;
        qtr_idx <= qtr_idx + 2'd1;
        if (qtr_idx == 2'd3) begin
          sec_cnt <= sec_inc;
        end
      end else begin
        qtr_cnt <= qtr_cnt + QW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      snz_cnt <= '0;
    end else if (clr_snz) begin
      snz_cnt <= '0;
    end else if (enter_snz) begin
      snz_cnt <= snz_cnt + NW'(1);
    end
  end

  assign ringing    = state[1];
  assign snoozing   = state[2];
  assign muted      = state[3];
  assign buzzer_out = tone_q & ~qtr_idx[1] & state[1];

endmodule

// File: tb/tb_alarm_buzzer_ctrl.sv
// Bench for alarm_buzzer_ctrl: vector table, directed corner sequences and
// random pulses checked against a cycle-count reference model.
module tb_alarm_buzzer_ctrl;

  localparam int TH   = 2;
  localparam int QC   = 8;
  localparam int RMAX = 3;
  localparam int SSEC = 2;
  localparam int MAXS = 1;
  localparam int RING_CYC = RMAX * 4 * QC;
  localparam int SNZ_CYC  = SSEC * 4 * QC;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic alarm_trig = 1'b0;
  logic snooze_pulse = 1'b0;
  logic stop_pulse = 1'b0;
  logic buzzer_out, ringing, snoozing, muted;

  alarm_buzzer_ctrl #(
    .TONE_HALF(TH), .QTR_CYCLES(QC), .RING_MAX(RMAX),
    .SNOOZE_SEC(SSEC), .MAX_SNOOZE(MAXS)
  ) dut (
    .clk(clk), .reset_n(reset_n), .alarm_trig(alarm_trig),
    .snooze_pulse(snooze_pulse), .stop_pulse(stop_pulse),
    .buzzer_out(buzzer_out), .ringing(ringing),
    .snoozing(snoozing), .muted(muted)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  // Reference model: mode 0 idle, 1 ringing, 2 snoozing, 3 muted.
  // m_t counts cycles since entering the current ring or snooze period.
  int m_mode = 0;
  int m_t = 0;
  int m_n = 0;

  function automatic logic m_buz();
    return (m_mode == 1) && (((m_t / TH) % 2) == 1) && (((m_t / QC) % 4) < 2);
  endfunction

  function automatic void m_reset();
    m_mode = 0; m_t = 0; m_n = 0;
  endfunction

  function automatic void m_edge(logic trig, logic snz, logic stp);
    case (m_mode)
      0: if (trig) begin m_mode = 1; m_t = 0; end
      1: begin
        if (!trig) begin m_mode = 0; m_n = 0; end
        else if (stp) m_mode = 3;
        else if (snz && m_n < MAXS) begin m_mode = 2; m_n++; m_t = 0; end
        else if (m_t + 1 == RING_CYC) m_mode = 3;
        else m_t++;
      end
      2: begin
        if (!trig) begin m_mode = 0; m_n = 0; end
        else if (stp) m_mode = 3;
        else if (m_t + 1 == SNZ_CYC) begin m_mode = 1; m_t = 0; end
        else m_t++;
      end
      default: if (!trig) begin m_mode = 0; m_n = 0; end
    endcase
  endfunction

  task automatic chk(input string name, input logic act, input logic exp);
    n_total++;
    if (act !== exp)
      $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
    else
      n_pass++;
  endtask

  task automatic chk_model();
    chk("model_buzzer", buzzer_out, m_buz());
    chk("model_ringing", ringing, m_mode == 1);
    chk("model_snoozing", snoozing, m_mode == 2);
    chk("model_muted", muted, m_mode == 3);
  endtask

  task automatic step(input logic trig, input logic snz, input logic stp);
    alarm_trig = trig; snooze_pulse = snz; stop_pulse = stp;
    @(posedge clk);
    m_edge(trig, snz, stp);
    #1;
    snooze_pulse = 1'b0; stop_pulse = 1'b0;
    chk_model();
  endtask

  task automatic chk_all(input string name, input logic r, input logic s,
                         input logic m, input logic b);
    chk({name, "_ringing"}, ringing, r);
    chk({name, "_snoozing"}, snoozing, s);
    chk({name, "_muted"}, muted, m);
    chk({name, "_buzzer"}, buzzer_out, b);
  endtask

  typedef struct {
    logic trig, snz, stp;
    logic e_ring, e_snz, e_mute, e_buz;
  } vec_t;

  vec_t tbl[13];

  initial begin
    tbl[0]  = '{1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0};
    tbl[1]  = '{1'b0,1'b1,1'b1, 1'b0,1'b0,1'b0,1'b0};
    tbl[2]  = '{1'b1,1'b0,1'b0, 1'b1,1'b0,1'b0,1'b0};
    tbl[3]  = '{1'b1,1'b0,1'b0, 1'b1,1'b0,1'b0,1'b0};
    tbl[4]  = '{1'b1,1'b0,1'b0, 1'b1,1'b0,1'b0,1'b1};
    tbl[5]  = '{1'b1,1'b0,1'b0, 1'b1,1'b0,1'b0,1'b1};
    tbl[6]  = '{1'b1,1'b1,1'b1, 1'b0,1'b0,1'b1,1'b0};
    tbl[7]  = '{1'b1,1'b1,1'b0, 1'b0,1'b0,1'b1,1'b0};
    tbl[8]  = '{1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0};
    tbl[9]  = '{1'b1,1'b0,1'b0, 1'b1,1'b0,1'b0,1'b0};
    tbl[10] = '{1'b1,1'b1,1'b0, 1'b0,1'b1,1'b0,1'b0};
    tbl[11] = '{1'b1,1'b0,1'b1, 1'b0,1'b0,1'b1,1'b0};
    tbl[12] = '{1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0};

    // Reset state
    #2;
    chk_all("reset", 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    m_reset();

    for (int i = 0; i < 13; i++) begin
      step(tbl[i].trig, tbl[i].snz, tbl[i].stp);
      chk_all($sformatf("vec%0d", i), tbl[i].e_ring, tbl[i].e_snz,
              tbl[i].e_mute, tbl[i].e_buz);
    end

    // Full ring with auto-mute after RING_CYC cycles
    step(1'b1, 1'b0, 1'b0);
    chk("ring_entry", ringing, 1'b1);
    for (int i = 1; i < RING_CYC; i++) begin
      step(1'b1, 1'b0, 1'b0);
      if (i == 2)  chk("tone_high_t2", buzzer_out, 1'b1);
      if (i == 16) chk("silence_t16", buzzer_out, 1'b0);
      if (i == 34) chk("tone_high_t34", buzzer_out, 1'b1);
      if (i == RING_CYC - 1) chk("not_muted_yet", muted, 1'b0);
    end
    step(1'b1, 1'b0, 1'b0);
    chk_all("auto_mute", 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    chk("mute_holds", muted, 1'b1);
    step(1'b0, 1'b0, 1'b0);
    chk_all("mute_release", 1'b0, 1'b0, 1'b0, 1'b0);

    // Snooze at ring cycle 5, wake after SNZ_CYC, second snooze refused
    step(1'b1, 1'b0, 1'b0);
    repeat (5) step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    chk_all("snooze_enter", 1'b0, 1'b1, 1'b0, 1'b0);
    repeat (SNZ_CYC - 1) step(1'b1, 1'b0, 1'b0);
    chk("snooze_still", snoozing, 1'b1);
    step(1'b1, 1'b0, 1'b0);
    chk_all("snooze_wake", 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    chk_all("snooze_limit", 1'b1, 1'b0, 1'b0, 1'b0);
    // Drop during ringing-after-snooze, re-arm and snooze is allowed again
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    chk("snooze_rearmed", snoozing, 1'b1);
    step(1'b0, 1'b0, 1'b0);
    chk_all("snooze_drop", 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    chk("snooze_after_drop", snoozing, 1'b1);
    step(1'b0, 1'b0, 1'b0);

    // Asynchronous reset while the tone is high
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    chk("pre_reset_tone", buzzer_out, 1'b1);
    reset_n = 1'b0;
    #1;
    chk_all("async_reset", 1'b0, 1'b0, 1'b0, 1'b0);
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_hold", ringing, 1'b0);
    reset_n = 1'b1;
    step(1'b1, 1'b0, 1'b0);
    chk_all("post_reset_t0", 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    chk("post_reset_t1", buzzer_out, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    chk("post_reset_t2", buzzer_out, 1'b1);

    // Random pulses against the model
    for (int i = 0; i < 3000; i++) begin
      logic t, s, p;
      t = ($urandom_range(0, 99) < 97);
      s = ($urandom_range(0, 99) < 4);
      p = ($urandom_range(0, 199) < 3);
      step(t, s, p);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/alarm_buzzer_ctrl.md
ALARM_BUZZER_CTRL -- requirements
Module: alarm_buzzer_ctrl

Interface
REQ-001 SHALL provide parameter TONE_HALF, default 5000: clk cycles per buzzer tone half-period (3.125 kHz at 31.25 MHz).
REQ-002 SHALL provide parameter QTR_CYCLES, default 7_812_500: clk cycles per quarter-second tick.
REQ-003 SHALL provide parameter RING_MAX, default 60: seconds of ringing before auto-mute.
REQ-004 SHALL provide parameter SNOOZE_SEC, default 300: snooze duration in seconds.
REQ-005 SHALL provide parameter MAX_SNOOZE, default 3: snoozes allowed per alarm event.
REQ-006 clk  input  1  system clock, 31.25 MHz; the only clock.
REQ-007 reset_n  input  1  asynchronous, active-low reset.
REQ-008 alarm_trig  input  1  level; high while alarm enabled and current time equals alarm time.
REQ-009 snooze_pulse  input  1  debounced one-cycle snooze request.
REQ-010 stop_pulse  input  1  debounced one-cycle stop request.
REQ-011 buzzer_out  output  1  gated tone to external buzzer driver.
REQ-012 ringing  output  1  high in RINGING.
REQ-013 snoozing  output  1  high in SNOOZE.
REQ-014 muted  output  1  high in MUTED.

Function
REQ-015 SHALL implement FSM with states IDLE, RINGING, SNOOZE, MUTED; ringing/snoozing/muted decode state directly from registers, no glitching logic.
REQ-016 IDLE: alarm_trig high at a clk edge -> RINGING at that edge; snooze/stop pulses ignored.
REQ-017 On every entry to RINGING: tone counter, tone flop, quarter counter, quarter index (2 bits) and ring-seconds counter all cleared to 0.
REQ-018 Tone: counter counts 0..TONE_HALF-1; on terminal count tone flop toggles and counter wraps to 0; runs only in RINGING.
REQ-019 Quarter tick: counter counts 0..QTR_CYCLES-1, tick on terminal count; quarter index increments mod 4 per tick; seconds counter increments when index wraps 3->0; runs in RINGING and SNOOZE.
REQ-020 buzzer_out SHALL be tone flop AND (quarter index < 2) AND state==RINGING: 0.5 s tone, 0.5 s silence.
REQ-021 RINGING: stop_pulse -> MUTED; else snooze_pulse with snooze count < MAX_SNOOZE -> SNOOZE, snooze count +1, quarter counter/index/seconds cleared; snooze_pulse at limit ignored.
REQ-022 RINGING: seconds counter reaching RING_MAX -> MUTED on the same edge the count would reach RING_MAX.
REQ-023 SNOOZE: seconds counter reaching SNOOZE_SEC -> RINGING (entry per REQ-017); stop_pulse -> MUTED; snooze_pulse ignored.
REQ-024 RINGING or SNOOZE: alarm_trig low -> IDLE, snooze count cleared; this has priority over all other transitions.
REQ-025 MUTED: stays until alarm_trig low, then IDLE with snooze count cleared; pulses ignored; no re-trigger while alarm_trig stays high.
REQ-026 Simultaneous stop_pulse and snooze_pulse: stop wins.
REQ-027 Counters SHALL be sized by $clog2 of their terminal values; no wrap beyond terminal value.

Reset
REQ-028 reset_n low SHALL asynchronously force IDLE, all counters and snooze count 0, tone flop 0; buzzer_out, ringing, snoozing, muted = 0.
REQ-029 Reset asserted mid-ring SHALL silence buzzer_out immediately (no clk needed); after release, re-entry to RINGING requires alarm_trig high at a clk edge.

Verification (bench parameters TONE_HALF=2, QTR_CYCLES=8, RING_MAX=3, SNOOZE_SEC=2, MAX_SNOOZE=1)
REQ-030 alarm_trig held high -> ringing=1 next edge; buzzer_out toggles every 2 cycles for 16 cycles, 0 for 16 cycles; muted=1 after 96 cycles of ringing.
REQ-031 snooze_pulse at ring cycle 5 -> snoozing=1, buzzer_out=0; after 64 cycles ringing=1 again; second snooze_pulse ignored (limit 1).
REQ-032 stop_pulse and snooze_pulse same cycle in RINGING -> muted=1, snoozing stays 0; alarm_trig low -> IDLE next edge, all outputs 0.
REQ-033 alarm_trig drops during SNOOZE -> IDLE next edge; re-raise -> RINGING with snooze allowed again.
REQ-034 reset_n pulsed low mid-tone-high -> buzzer_out 0 asynchronously; after release with alarm_trig high, ringing=1 at first edge, tone phase restarted from 0.
